pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Sequences the 5-stage pipeline around the decode stage: per-stage enables, load-use bubbles,
//  taken-branch flushes and data-memory wait stalls. Sits beside IF/ID/EX/MEM.
//  Drives PC-register enable/select, the IF/ID and ID/EX register enables, and the ID/EX bubble.
//  FSM: RUN, FLUSH, MEM_WAIT, HALT.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles IF/ID stays flushed after a taken branch (>=1)
//  MEM_TIMEOUT   15  max consecutive MEM_WAIT cycles before HALT (>=1)
// PORTS
//  i_clk            in   1   clock; all state updates on posedge
//  i_rst            in   1   reset: asynchronous, active-high
//  i_id_valid       in   1   IF/ID holds a real instruction
//  i_id_rs1_index   in   5   rs1 of instruction in decode
//  i_id_rs2_index   in   5   rs2 of instruction in decode
//  i_ex_valid       in   1   ID/EX holds a real instruction
//  i_ex_mem_read    in   1   instruction in EX is a load
//  i_ex_rd_index    in   5   destination of instruction in EX
//  i_branch_taken   in   1   branch resolved taken in EX/MEM (1-cycle pulse)
//  i_branch_target  in   64  taken-branch target PC
//  i_dmem_req       in   1   MEM stage has an outstanding data access
//  i_dmem_ready     in   1   data memory completes access this cycle
//  o_pc_enable      out  1   PC register load enable
//  o_pc_sel         out  1   1: PC <= o_pc_target, 0: PC <= PC+4
//  o_pc_target      out  64  redirect target
//  o_if_id_enable   out  1   IF/ID register load enable
//  o_id_ex_enable   out  1   ID/EX register load enable
//  o_id_ex_bubble   out  1   ID/EX loads a NOP (all control bits 0)
//  o_flush_if_id    out  1   IF/ID loads a NOP
//  o_halt           out  1   sticky: memory timeout; cleared only by reset
// BEHAVIOUR
//  - State, counters, pending-branch reg are flops; outputs combinational from state + inputs.
//  - Reset (async, i_rst=1): state=RUN, counters=0, pending=0; all outputs forced 0 while asserted.
//    Reset mid-FLUSH/MEM_WAIT/HALT aborts immediately; no pending redirect survives.
//  - hazard = i_id_valid & i_ex_valid & i_ex_mem_read & (i_ex_rd_index!=0)
//             & (i_ex_rd_index==i_id_rs1_index | i_ex_rd_index==i_id_rs2_index).
//  - memwait = i_dmem_req & ~i_dmem_ready.
//  - RUN, priority memwait > branch > hazard > none:
//    memwait: all enables 0; if i_branch_taken, latch target, pending=1; -> MEM_WAIT, wcnt=1.
//    branch: pc_enable=1, pc_sel=1, target=i_branch_target, flush_if_id=1, id_ex_bubble=1,
//            enables 1; -> FLUSH with fcnt=FLUSH_CYCLES-1 (stay RUN if FLUSH_CYCLES==1).
//    hazard: pc_enable=0, if_id_enable=0, id_ex_enable=1, id_ex_bubble=1; stay RUN
//            (bubble clears i_ex_valid next cycle: exactly 1 stall cycle per load-use).
//    none: all enables 1, pc_sel=0, no flush/bubble.
//  - FLUSH: enables 1, flush_if_id=1, id_ex_bubble=1, pc_sel=0; fcnt-- ; fcnt==1 -> RUN.
//    Hazard ignored (ID is flushed). memwait in FLUSH -> MEM_WAIT; flush resumes afterwards
//    (fcnt preserved). New branch_taken in FLUSH restarts redirect as in RUN.
//  - MEM_WAIT: all enables 0. Each cycle memwait, wcnt++; wcnt==MEM_TIMEOUT & memwait -> HALT.
//    ~memwait: if pending, act as RUN-branch with latched target, pending=0; else return to
//    prior state (RUN or FLUSH). Ready on the same cycle as timeout wins (no HALT).
//  - HALT: all enables 0, o_halt=1; exit only by reset.
//  - o_pc_target = latched target when pending, else i_branch_target; 0 when pc_sel=0.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: extra outputs o_stall_cycles[31:0], o_flush_events[31:0],
//   o_mem_wait_cycles[31:0]; count hazard-stall cycles, branch redirects, MEM_WAIT cycles;
//   saturate at 32'hFFFF_FFFF; reset to 0. Undefined: ports and counters absent; other
//   behaviour identical.
// TESTING
//  1 ld x5 in EX, ID uses rs1=5 -> 1 cycle pc/if_id_enable=0, bubble=1; rd=0 -> no stall.
//  2 branch_taken, target 0x1000 -> pc_sel=1, target 0x1000, flush_if_id high 2 cycles.
//  3 dmem_req, ready after 4 cycles -> enables low exactly 4 cycles, then RUN.
//  4 memwait + branch_taken same cycle (target 0x2000) -> redirect to 0x2000 on wait exit.
//  5 ready never asserted -> HALT after 15 wait cycles; o_halt stays 1 until i_rst.
//  6 i_rst pulsed mid-MEM_WAIT with pending branch -> outputs 0 at once, RUN, no redirect.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Decode-stage hazard/flow controller for a 5-stage pipeline: load-use stalls, branch flushes,
// data-memory wait stalls with timeout halt. Optional counters under HAZARD_PERF_CNT_EN.
module pipeline_hazard_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs1_index,
  input  logic [4:0]  i_id_rs2_index,
  input  logic        i_ex_valid,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_ex_rd_index,
  input  logic        i_branch_taken,
  input  logic [63:0] i_branch_target,
  input  logic        i_dmem_req,
  input  logic        i_dmem_ready,
  output logic        o_pc_enable,
  output logic        o_pc_sel,
  output logic [63:0] o_pc_target,
  output logic        o_if_id_enable,
  output logic        o_id_ex_enable,
  output logic        o_id_ex_bubble,
  output logic        o_flush_if_id,
  output logic        o_halt
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_events,
  output logic [31:0] o_mem_wait_cycles
`endif
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FW-1:0] FCNT_INIT = FW'(FLUSH_CYCLES - 1);
  localparam logic [WW-1:0] WCNT_MAX  = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_MEM_WAIT, S_HALT} state_t;

  state_t        r_state, w_state_next;
  logic [FW-1:0] r_fcnt, w_fcnt_next;
  logic [WW-1:0] r_wcnt, w_wcnt_next;
  logic          r_pending, w_pending_next;
  logic [63:0]   r_target, w_target_next;
  logic          r_prior_flush, w_prior_flush_next;

  logic w_hazard, w_memwait;
  logic w_act_run, w_act_flush, w_redirect, w_use_latched;
  logic w_pc_enable, w_pc_sel, w_if_id_enable, w_id_ex_enable, w_id_ex_bubble, w_flush, w_halt;
  logic [63:0] w_pc_target;

  assign w_hazard = i_id_valid & i_ex_valid & i_ex_mem_read & (i_ex_rd_index != 5'd0) &
                    ((i_ex_rd_index == i_id_rs1_index) | (i_ex_rd_index == i_id_rs2_index));
  assign w_memwait = i_dmem_req & ~i_dmem_ready;

  always_comb begin
    w_state_next       = r_state;
    w_fcnt_next        = r_fcnt;
    w_wcnt_next        = r_wcnt;
    w_pending_next     = r_pending;
    w_target_next      = r_target;
    w_prior_flush_next = r_prior_flush;
    w_act_run          = 1'b0;
    w_act_flush        = 1'b0;
    w_redirect         = 1'b0;
    w_use_latched      = 1'b0;
    w_pc_enable        = 1'b0;
    w_pc_sel           = 1'b0;
    w_if_id_enable     = 1'b0;
    w_id_ex_enable     = 1'b0;
    w_id_ex_bubble     = 1'b0;
    w_flush            = 1'b0;
    w_halt             = 1'b0;

    case (r_state)
      S_RUN:   w_act_run = 1'b1;
      S_FLUSH: w_act_flush = 1'b1;
      S_MEM_WAIT: begin
        if (w_memwait) begin
          if (r_wcnt == WCNT_MAX) w_state_next = S_HALT;
          else w_wcnt_next = r_wcnt + WW'(1);
          if (i_branch_taken) begin
            w_pending_next = 1'b1;
            w_target_next  = i_branch_target;
          end
        end else if (r_pending) begin
          w_redirect    = 1'b1;
          w_use_latched = 1'b1;
        end else if (r_prior_flush) begin
          w_act_flush = 1'b1;
        end else begin
          w_act_run = 1'b1;
        end
      end
      S_HALT:  w_halt = 1'b1;
      default: w_state_next = S_RUN;
    endcase

    // RUN and FLUSH share the memwait/branch front end; a finished wait re-enters here too.
    if (w_act_run || w_act_flush) begin
      if (w_memwait) begin
        w_state_next       = S_MEM_WAIT;
        w_wcnt_next        = WW'(1);
        w_prior_flush_next = w_act_flush;
        if (i_branch_taken) begin
          w_pending_next = 1'b1;
          w_target_next  = i_branch_target;
        end
      end else if (i_branch_taken) begin
        w_redirect = 1'b1;
      end else if (w_act_flush) begin
        w_pc_enable    = 1'b1;
        w_if_id_enable = 1'b1;
        w_id_ex_enable = 1'b1;
        w_id_ex_bubble = 1'b1;
        w_flush        = 1'b1;
        if (r_fcnt <= FW'(1)) begin
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_FLUSH;
          w_fcnt_next  = r_fcnt - FW'(1);
        end
      end else if (w_hazard) begin
        w_id_ex_enable = 1'b1;
        w_id_ex_bubble = 1'b1;
        w_state_next   = S_RUN;
      end else begin
        w_pc_enable    = 1'b1;
        w_if_id_enable = 1'b1;
        w_id_ex_enable = 1'b1;
        w_state_next   = S_RUN;
      end
    end

    if (w_redirect) begin
      w_pc_enable    = 1'b1;
      w_pc_sel       = 1'b1;
      w_if_id_enable = 1'b1;
      w_id_ex_enable = 1'b1;
      w_id_ex_bubble = 1'b1;
      w_flush        = 1'b1;
      w_pending_next = 1'b0;
      w_fcnt_next    = FCNT_INIT;
      w_state_next   = (FLUSH_CYCLES == 1) ? S_RUN : S_FLUSH;
    end
  end

  assign w_pc_target = w_pc_sel ? (w_use_latched ? r_target : i_branch_target) : 64'd0;

  // Reset is asynchronous, so the outputs are gated directly rather than waiting for a clock.
  assign o_pc_enable    = w_pc_enable & ~i_rst;
  assign o_pc_sel       = w_pc_sel & ~i_rst;
  assign o_pc_target    = i_rst ? 64'd0 : w_pc_target;
  assign o_if_id_enable = w_if_id_enable & ~i_rst;
  assign o_id_ex_enable = w_id_ex_enable & ~i_rst;
  assign o_id_ex_bubble = w_id_ex_bubble & ~i_rst;
  assign o_flush_if_id  = w_flush & ~i_rst;
  assign o_halt         = w_halt & ~i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_RUN;
      r_fcnt        <= '0;
      r_wcnt        <= '0;
      r_pending     <= 1'b0;
      r_target      <= 64'd0;
      r_prior_flush <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_fcnt        <= w_fcnt_next;
      r_wcnt        <= w_wcnt_next;
      r_pending     <= w_pending_next;
      r_target      <= w_target_next;
      r_prior_flush <= w_prior_flush_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt, r_wait_cnt;
  logic        w_stall;

  // A bubble with the PC held is exactly a load-use stall cycle.
  assign w_stall = w_id_ex_bubble & ~w_pc_enable;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
      r_wait_cnt  <= 32'd0;
    end else begin
      if (w_stall && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_pc_sel && r_flush_cnt != 32'hFFFF_FFFF) r_flush_cnt <= r_flush_cnt + 32'd1;
      if (r_state == S_MEM_WAIT && r_wait_cnt != 32'hFFFF_FFFF) r_wait_cnt <= r_wait_cnt + 32'd1;
    end
  end

  assign o_stall_cycles    = r_stall_cnt;
  assign o_flush_events    = r_flush_cnt;
  assign o_mem_wait_cycles = r_wait_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: per-cycle expected control vectors are
// queued as stimulus is driven and compared against the combinational outputs mid-cycle.
module tb_pipeline_hazard_controller;

  logic        i_clk;
  logic        i_rst;
  logic        i_id_valid;
  logic [4:0]  i_id_rs1_index;
  logic [4:0]  i_id_rs2_index;
  logic        i_ex_valid;
  logic        i_ex_mem_read;
  logic [4:0]  i_ex_rd_index;
  logic        i_branch_taken;
  logic [63:0] i_branch_target;
  logic        i_dmem_req;
  logic        i_dmem_ready;
  logic        o_pc_enable;
  logic        o_pc_sel;
  logic [63:0] o_pc_target;
  logic        o_if_id_enable;
  logic        o_id_ex_enable;
  logic        o_id_ex_bubble;
  logic        o_flush_if_id;
  logic        o_halt;

  pipeline_hazard_controller dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_id_valid      (i_id_valid),
    .i_id_rs1_index  (i_id_rs1_index),
    .i_id_rs2_index  (i_id_rs2_index),
    .i_ex_valid      (i_ex_valid),
    .i_ex_mem_read   (i_ex_mem_read),
    .i_ex_rd_index   (i_ex_rd_index),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_dmem_req      (i_dmem_req),
    .i_dmem_ready    (i_dmem_ready),
    .o_pc_enable     (o_pc_enable),
    .o_pc_sel        (o_pc_sel),
    .o_pc_target     (o_pc_target),
    .o_if_id_enable  (o_if_id_enable),
    .o_id_ex_enable  (o_id_ex_enable),
    .o_id_ex_bubble  (o_id_ex_bubble),
    .o_flush_if_id   (o_flush_if_id),
    .o_halt          (o_halt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        rst;
    logic        idv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exv;
    logic        mrd;
    logic [4:0]  rd;
    logic        br;
    logic [63:0] tgt;
    logic        req;
    logic        rdy;
  } stim_t;

  // {pc_en, pc_sel, if_id_en, id_ex_en, bubble, flush, halt, pc_target}
  localparam logic [70:0] E_ZERO  = {7'b0000000, 64'd0};
  localparam logic [70:0] E_RUN   = {7'b1011000, 64'd0};
  localparam logic [70:0] E_STALL = {7'b0001100, 64'd0};
  localparam logic [70:0] E_WAIT  = {7'b0000000, 64'd0};
  localparam logic [70:0] E_FLUSH = {7'b1011110, 64'd0};
  localparam logic [70:0] E_HALT  = {7'b0000001, 64'd0};

  logic [70:0] sb[$];
  int n_cmp = 0;
  int n_mis = 0;

  function automatic logic [70:0] e_redir(input logic [63:0] t);
    return {7'b1111110, t};
  endfunction

  function automatic logic [70:0] obs();
    return {o_pc_enable, o_pc_sel, o_if_id_enable, o_id_ex_enable, o_id_ex_bubble,
            o_flush_if_id, o_halt, o_pc_target};
  endfunction

  function automatic stim_t st(input logic rst, input logic idv, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic exv, input logic mrd,
                               input logic [4:0] rd, input logic br, input logic [63:0] tgt,
                               input logic req, input logic rdy);
    stim_t s;
    s = '{rst, idv, rs1, rs2, exv, mrd, rd, br, tgt, req, rdy};
    return s;
  endfunction

  function automatic stim_t s_idle();
    return st(0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 0);
  endfunction

  function automatic stim_t s_mem(input logic req, input logic rdy, input logic br,
                                  input logic [63:0] tgt);
    return st(0, 0, 0, 0, 0, 0, 0, br, tgt, req, rdy);
  endfunction

  function automatic stim_t s_br(input logic [63:0] tgt);
    return st(0, 0, 0, 0, 0, 0, 0, 1, tgt, 0, 0);
  endfunction

  task automatic apply(input stim_t s);
    i_rst           = s.rst;
    i_id_valid      = s.idv;
    i_id_rs1_index  = s.rs1;
    i_id_rs2_index  = s.rs2;
    i_ex_valid      = s.exv;
    i_ex_mem_read   = s.mrd;
    i_ex_rd_index   = s.rd;
    i_branch_taken  = s.br;
    i_branch_target = s.tgt;
    i_dmem_req      = s.req;
    i_dmem_ready    = s.rdy;
  endtask

  task automatic test_reset();
    stim_t q[$];
    logic [70:0] act, exp_v;
    q.push_back(st(1, 1, 5, 0, 1, 1, 5, 1, 64'h1000, 0, 0)); sb.push_back(E_ZERO);
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 1, 64'h1234, 1, 0)); sb.push_back(E_ZERO);
    q.push_back(s_idle());                                    sb.push_back(E_RUN);
    q.push_back(s_idle());                                    sb.push_back(E_RUN);
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      #1;
      act = obs();
      exp_v = sb.pop_front();
      n_cmp++;
      if (act !== exp_v) begin
        n_mis++;
        $display("FAIL reset[%0d]: got %h, expected %h", i, act, exp_v);
      end else $display("ok reset[%0d] %h", i, act);
      @(negedge i_clk);
    end
  endtask

  task automatic test_load_use();
    stim_t q[$];
    logic [70:0] act, exp_v;
    q.push_back(st(0, 1, 5, 3, 1, 1, 5, 0, 64'd0, 0, 0)); sb.push_back(E_STALL);
    q.push_back(st(0, 1, 5, 3, 0, 0, 0, 0, 64'd0, 0, 0)); sb.push_back(E_RUN);
    q.push_back(st(0, 1, 2, 9, 1, 1, 9, 0, 64'd0, 0, 0)); sb.push_back(E_STALL);
    q.push_back(st(0, 1, 2, 9, 0, 0, 0, 0, 64'd0, 0, 0)); sb.push_back(E_RUN);
    q.push_back(st(0, 1, 0, 0, 1, 1, 0, 0, 64'd0, 0, 0)); sb.push_back(E_RUN);
    q.push_back(st(0, 0, 5, 5, 1, 1, 5, 0, 64'd0, 0, 0)); sb.push_back(E_RUN);
    q.push_back(st(0, 1, 5, 5, 1, 0, 5, 0, 64'd0, 0, 0)); sb.push_back(E_RUN);
    q.push_back(st(0, 1, 4, 6, 1, 1, 5, 0, 64'd0, 0, 0)); sb.push_back(E_RUN);
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      #1;
      act = obs();
      exp_v = sb.pop_front();
      n_cmp++;
      if (act !== exp_v) begin
        n_mis++;
        $display("FAIL load_use[%0d]: got %h, expected %h", i, act, exp_v);
      end else $display("ok load_use[%0d] %h", i, act);
      @(negedge i_clk);
    end
  endtask

  task automatic test_branch();
    stim_t q[$];
    logic [70:0] act, exp_v;
    q.push_back(s_br(64'h1000));                          sb.push_back(e_redir(64'h1000));
    q.push_back(st(0, 1, 5, 0, 1, 1, 5, 0, 64'd0, 0, 0)); sb.push_back(E_FLUSH);
    q.push_back(s_idle());                                sb.push_back(E_RUN);
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      #1;
      act = obs();
      exp_v = sb.pop_front();
      n_cmp++;
      if (act !== exp_v) begin
        n_mis++;
        $display("FAIL branch[%0d]: got %h, expected %h", i, act, exp_v);
      end else $display("ok branch[%0d] %h", i, act);
      @(negedge i_clk);
    end
  endtask

  task automatic test_mem_wait();
    stim_t q[$];
    logic [70:0] act, exp_v;
    for (int k = 0; k < 4; k++) begin
      q.push_back(s_mem(1, 0, 0, 64'd0)); sb.push_back(E_WAIT);
    end
    q.push_back(s_mem(1, 1, 0, 64'd0)); sb.push_back(E_RUN);
    q.push_back(s_idle());              sb.push_back(E_RUN);
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      #1;
      act = obs();
      exp_v = sb.pop_front();
      n_cmp++;
      if (act !== exp_v) begin
        n_mis++;
        $display("FAIL mem_wait[%0d]: got %h, expected %h", i, act, exp_v);
      end else $display("ok mem_wait[%0d] %h", i, act);
      @(negedge i_clk);
    end
  endtask

  task automatic test_wait_branch();
    stim_t q[$];
    logic [70:0] act, exp_v;
    q.push_back(s_mem(1, 0, 1, 64'h2000)); sb.push_back(E_WAIT);
    q.push_back(s_mem(1, 0, 0, 64'hDEAD)); sb.push_back(E_WAIT);
    q.push_back(s_mem(1, 1, 0, 64'h3333)); sb.push_back(e_redir(64'h2000));
    q.push_back(s_idle());                 sb.push_back(E_FLUSH);
    q.push_back(s_idle());                 sb.push_back(E_RUN);
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      #1;
      act = obs();
      exp_v = sb.pop_front();
      n_cmp++;
      if (act !== exp_v) begin
        n_mis++;
        $display("FAIL wait_branch[%0d]: got %h, expected %h", i, act, exp_v);
      end else $display("ok wait_branch[%0d] %h", i, act);
      @(negedge i_clk);
    end
  endtask

  task automatic test_flush_wait();
    stim_t q[$];
    logic [70:0] act, exp_v;
    q.push_back(s_br(64'h40));          sb.push_back(e_redir(64'h40));
    q.push_back(s_mem(1, 0, 0, 64'd0)); sb.push_back(E_WAIT);
    q.push_back(s_mem(1, 0, 0, 64'd0)); sb.push_back(E_WAIT);
    q.push_back(s_mem(1, 1, 0, 64'd0)); sb.push_back(E_FLUSH);
    q.push_back(s_idle());              sb.push_back(E_RUN);
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      #1;
      act = obs();
      exp_v = sb.pop_front();
      n_cmp++;
      if (act !== exp_v) begin
        n_mis++;
        $display("FAIL flush_wait[%0d]: got %h, expected %h", i, act, exp_v);
      end else $display("ok flush_wait[%0d] %h", i, act);
      @(negedge i_clk);
    end
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    logic [70:0] act, exp_v;
    q.push_back(s_br(64'h100)); sb.push_back(e_redir(64'h100));
    q.push_back(s_br(64'h200)); sb.push_back(e_redir(64'h200));
    q.push_back(s_idle());      sb.push_back(E_FLUSH);
    q.push_back(s_idle());      sb.push_back(E_RUN);
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      #1;
      act = obs();
      exp_v = sb.pop_front();
      n_cmp++;
      if (act !== exp_v) begin
        n_mis++;
        $display("FAIL back_to_back[%0d]: got %h, expected %h", i, act, exp_v);
      end else $display("ok back_to_back[%0d] %h", i, act);
      @(negedge i_clk);
    end
  endtask

  task automatic test_ready_at_timeout();
    stim_t q[$];
    logic [70:0] act, exp_v;
    for (int k = 0; k < 15; k++) begin
      q.push_back(s_mem(1, 0, 0, 64'd0)); sb.push_back(E_WAIT);
    end
    q.push_back(s_mem(1, 1, 0, 64'd0)); sb.push_back(E_RUN);
    q.push_back(s_idle());              sb.push_back(E_RUN);
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      #1;
      act = obs();
      exp_v = sb.pop_front();
      n_cmp++;
      if (act !== exp_v) begin
        n_mis++;
        $display("FAIL ready_at_timeout[%0d]: got %h, expected %h", i, act, exp_v);
      end else $display("ok ready_at_timeout[%0d] %h", i, act);
      @(negedge i_clk);
    end
  endtask

  task automatic test_timeout_halt();
    stim_t q[$];
    logic [70:0] act, exp_v;
    for (int k = 0; k < 16; k++) begin
      q.push_back(s_mem(1, 0, 0, 64'd0)); sb.push_back(E_WAIT);
    end
    q.push_back(s_mem(1, 0, 0, 64'd0)); sb.push_back(E_HALT);
    q.push_back(s_mem(1, 1, 0, 64'd0)); sb.push_back(E_HALT);
    q.push_back(s_br(64'h7000));        sb.push_back(E_HALT);
    q.push_back(s_idle());              sb.push_back(E_HALT);
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 0)); sb.push_back(E_ZERO);
    q.push_back(s_idle());              sb.push_back(E_RUN);
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      #1;
      act = obs();
      exp_v = sb.pop_front();
      n_cmp++;
      if (act !== exp_v) begin
        n_mis++;
        $display("FAIL timeout_halt[%0d]: got %h, expected %h", i, act, exp_v);
      end else $display("ok timeout_halt[%0d] %h", i, act);
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset_mid_wait();
    stim_t q[$];
    logic [70:0] act, exp_v;
    q.push_back(s_mem(1, 0, 1, 64'h5000)); sb.push_back(E_WAIT);
    q.push_back(s_mem(1, 0, 0, 64'd0));    sb.push_back(E_WAIT);
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 64'd0, 1, 1)); sb.push_back(E_ZERO);
    q.push_back(s_mem(1, 1, 0, 64'd0));    sb.push_back(E_RUN);
    q.push_back(s_idle());                 sb.push_back(E_RUN);
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      #1;
      act = obs();
      exp_v = sb.pop_front();
      n_cmp++;
      if (act !== exp_v) begin
        n_mis++;
        $display("FAIL reset_mid_wait[%0d]: got %h, expected %h", i, act, exp_v);
      end else $display("ok reset_mid_wait[%0d] %h", i, act);
      @(negedge i_clk);
    end
  endtask

  initial begin
    apply(st(1, 0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 0));
    @(negedge i_clk);
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_wait_branch();
    test_flush_wait();
    test_back_to_back();
    test_ready_at_timeout();
    test_timeout_halt();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
